// File: rtl/apple_video_pkg.sv
// rtl/apple_video_pkg.sv - shared types, constants and row-base helper for the Apple II video fetch path
package apple_video_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } fetch_state_t;

  localparam logic [15:0] TEXT_BASE       = 16'h0400;
  localparam logic [15:0] HIRES_BASE      = 16'h2000;
  localparam logic [15:0] PAGE2_TEXT_OFS  = 16'h0400;
  localparam logic [15:0] PAGE2_HIRES_OFS = 16'h2000;

  // Byte address of the first column of a scanline; Apple II rows are interleaved
  // in groups of 8 (x128) and thirds of the screen (x40), hires adds the 1 KB sub-row.
  function automatic logic [15:0] row_base(input logic [7:0] line,
                                           input logic hires,
                                           input logic page2);
    logic [15:0] base;
    if (hires) begin
      base = HIRES_BASE + (page2 ? PAGE2_HIRES_OFS : 16'h0000) + {3'b000, line[2:0], 10'b0};
    end else begin
      base = TEXT_BASE + (page2 ? PAGE2_TEXT_OFS : 16'h0000);
    end
    base = base + {6'b0, line[5:3], 7'b0} + (16'(line[7:6]) * 16'd40);
    return base;
  endfunction

endpackage

// File: rtl/line_buffer_pp.sv
// rtl/line_buffer_pp.sv - 2x40x16 ping-pong line buffer, word-wide write, registered column read
module line_buffer_pp
  import apple_video_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [4:0]  wr_word,
  input  logic [31:0] wr_data,
  input  logic        swap,
  input  logic [5:0]  rd_addr,
  output logic [15:0] rd_data
);

  localparam logic [5:0] NUM_COLS = 6'd40;

  // Each entry holds one SDRAM word = two columns; index is {bank, word}.
  logic [31:0] ram [0:63];
  logic        fill_bank;
  logic        render_bank;
  logic [5:0]  wr_idx;
  logic [5:0]  rd_idx;

  assign render_bank = ~fill_bank;
  assign wr_idx      = {fill_bank, wr_word};
  assign rd_idx      = {render_bank, rd_addr[5:1]};

  // Bank select: the fill bank toggles when a complete line is handed to the renderer.
  always_ff @(posedge clk) begin
    if (reset) begin
      fill_bank <= 1'b0;
    end else if (swap) begin
      fill_bank <= ~fill_bank;
    end
  end

  // Write port: contents need no reset, they are only shown after a full line lands.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      ram[wr_idx] <= wr_data;
    end
  end

  // Registered read from the render bank; even column is the low half of the word.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= 16'h0000;
    end else if (rd_addr >= NUM_COLS) begin
      rd_data <= 16'h0000;
    end else if (rd_addr[0]) begin
      rd_data <= ram[rd_idx][31:16];
    end else begin
      rd_data <= ram[rd_idx][15:0];
    end
  end

endmodule

// File: rtl/apple_line_fetch.sv
// rtl/apple_line_fetch.sv - per-scanline SDRAM row fetch into a ping-pong line buffer
module apple_line_fetch
  import apple_video_pkg::*;
#(
  parameter int WORDS_PER_LINE = 20,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_WIDTH     = 21
)
(
  input  logic                  clk_logic,
  input  logic                  system_reset,
  input  logic                  line_start_i,
  input  logic [7:0]            line_i,
  input  logic                  hires_i,
  input  logic                  page2_i,
  input  logic                  bank_i,
  output logic                  mem_rd_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_ready_i,
  input  logic                  mem_available_i,
  input  logic [31:0]           mem_q_i,
  input  logic [5:0]            buf_addr_i,
  output logic [15:0]           buf_data_o,
  output logic                  busy_o,
  output logic                  line_done_o,
  output logic                  overrun_o,
  output logic                  timeout_o
);

  localparam int              TW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [4:0]      K_LAST = 5'(WORDS_PER_LINE - 1);
  localparam logic [TW-1:0]   T_LAST = TW'(TIMEOUT_CYCLES - 1);

  fetch_state_t  state;
  fetch_state_t  state_nx;
  logic [14:0]   base_word_l;
  logic          bank_l;
  logic [4:0]    k;
  logic [TW-1:0] timer;
  logic [15:0]   row_base_w;
  logic          unused_base_lsb;
  logic [14:0]   word_addr;
  logic          last_word;
  logic          take_data;
  logic          swap;

  // The row base is always even, so only its word part is kept.
  assign row_base_w      = row_base(line_i, hires_i, page2_i);
  assign unused_base_lsb = row_base_w[0];

  assign last_word  = (k == K_LAST);
  assign take_data  = ((state == ST_REQ) && mem_ready_i && mem_available_i) ||
                      ((state == ST_WAIT) && mem_available_i);
  assign word_addr  = base_word_l + {10'b0, k};
  assign mem_addr_o = {{(ADDR_WIDTH-16){1'b0}}, bank_l, word_addr};

  // State register.
  always_ff @(posedge clk_logic) begin
    if (system_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state: one request outstanding; data may arrive in the accept cycle.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (line_start_i) state_nx = ST_REQ;
      end
      ST_REQ: begin
        if (mem_ready_i) begin
          if (mem_available_i) state_nx = last_word ? ST_DONE : ST_REQ;
          else                 state_nx = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_available_i)      state_nx = last_word ? ST_DONE : ST_REQ;
        else if (timer == T_LAST) state_nx = ST_IDLE;
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Moore outputs decoded from state.
  always_comb begin
    mem_rd_o    = 1'b0;
    busy_o      = 1'b0;
    line_done_o = 1'b0;
    swap        = 1'b0;
    case (state)
      ST_REQ:  begin mem_rd_o = 1'b1; busy_o = 1'b1; end
      ST_WAIT: busy_o = 1'b1;
      ST_DONE: begin busy_o = 1'b1; line_done_o = 1'b1; swap = 1'b1; end
      default: ;
    endcase
  end

  // Line parameters latched at the start strobe, word index and response timer.
  always_ff @(posedge clk_logic) begin
    if (system_reset) begin
      base_word_l <= 15'd0;
      bank_l      <= 1'b0;
      k           <= 5'd0;
      timer       <= '0;
    end else begin
      if ((state == ST_IDLE) && line_start_i) begin
        base_word_l <= row_base_w[15:1];
        bank_l      <= bank_i;
        k           <= 5'd0;
      end
      if ((state == ST_REQ) && mem_ready_i) begin
        timer <= '0;
      end else if (state == ST_WAIT) begin
        timer <= timer + TW'(1);
      end
      if (take_data && !last_word) begin
        k <= k + 5'd1;
      end
    end
  end

  // Error pulses, registered so they appear the cycle after the event.
  always_ff @(posedge clk_logic) begin
    if (system_reset) begin
      overrun_o <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      overrun_o <= line_start_i && (state != ST_IDLE);
      timeout_o <= (state == ST_WAIT) && !mem_available_i && (timer == T_LAST);
    end
  end

  line_buffer_pp u_buf (
    .clk     (clk_logic),
    .reset   (system_reset),
    .wr_en   (take_data),
    .wr_word (k),
    .wr_data (mem_q_i),
    .swap    (swap),
    .rd_addr (buf_addr_i),
    .rd_data (buf_data_o)
  );

endmodule

// File: tb/tb_apple_line_fetch.sv
// tb/tb_apple_line_fetch.sv - self-checking bench for apple_line_fetch
module tb_apple_line_fetch;

  logic        clk_logic = 1'b0;
  logic        system_reset = 1'b1;
  logic        line_start_i = 1'b0;
  logic [7:0]  line_i = 8'd0;
  logic        hires_i = 1'b0;
  logic        page2_i = 1'b0;
  logic        bank_i = 1'b0;
  logic        mem_rd_o;
  logic [20:0] mem_addr_o;
  logic        mem_ready_i = 1'b0;
  logic        mem_available_i = 1'b0;
  logic [31:0] mem_q_i = 32'd0;
  logic [5:0]  buf_addr_i = 6'd0;
  logic [15:0] buf_data_o;
  logic        busy_o;
  logic        line_done_o;
  logic        overrun_o;
  logic        timeout_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] wdata [20];
  logic [15:0] model [40];

  apple_line_fetch dut (
    .clk_logic       (clk_logic),
    .system_reset    (system_reset),
    .line_start_i    (line_start_i),
    .line_i          (line_i),
    .hires_i         (hires_i),
    .page2_i         (page2_i),
    .bank_i          (bank_i),
    .mem_rd_o        (mem_rd_o),
    .mem_addr_o      (mem_addr_o),
    .mem_ready_i     (mem_ready_i),
    .mem_available_i (mem_available_i),
    .mem_q_i         (mem_q_i),
    .buf_addr_i      (buf_addr_i),
    .buf_data_o      (buf_data_o),
    .busy_o          (busy_o),
    .line_done_o     (line_done_o),
    .overrun_o       (overrun_o),
    .timeout_o       (timeout_o)
  );

  always #5 clk_logic = ~clk_logic;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_logic);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference address: Apple II row layout computed with plain integer arithmetic.
  function automatic logic [31:0] exp_addr(input int line, input bit hires, input bit page2,
                                           input bit bank, input int k);
    int base;
    if (hires) base = 'h2000 + (page2 ? 'h2000 : 0) + (line % 8) * 1024;
    else       base = 'h0400 + (page2 ? 'h0400 : 0);
    base = base + ((line / 8) % 8) * 128 + (line / 64) * 40;
    base = (base + 2 * k) & 'hFFFF;
    return 32'((bank ? 'h8000 : 0) | (base >> 1));
  endfunction

  task automatic check_buffer(input string tag);
    // Stray data strobe while idle must not disturb anything.
    mem_available_i = 1'b1;
    mem_q_i = $urandom;
    tick();
    mem_available_i = 1'b0;
    for (int a = 0; a < 42; a++) begin
      buf_addr_i = 6'(a);
      tick();
      chk($sformatf("%s_buf%0d", tag, a), {16'h0, buf_data_o},
          (a < 40) ? {16'h0, model[a]} : 32'h0);
    end
  endtask

  task automatic run_line(input int line, input bit hires, input bit page2, input bit bank,
                          input int exp_first, input int long_stall_at, input int overrun_at,
                          input int reset_at, input bit mix, input bit start_at_done,
                          input bit force5);
    int n;
    int stall;
    logic [31:0] a;
    for (int k = 0; k < 20; k++) wdata[k] = $urandom;
    if (force5) wdata[5] = 32'hDDCCBBAA;
    line_i = 8'(line); hires_i = hires; page2_i = page2; bank_i = bank;
    line_start_i = 1'b1;
    tick();
    line_start_i = 1'b0;
    line_i = 8'($urandom_range(0, 191)); hires_i = 1'($urandom); bank_i = 1'($urandom);
    for (int k = 0; k < 20; k++) begin
      n = 0;
      while (!mem_rd_o && n < 20) begin tick(); n++; end
      chk($sformatf("rd_req%0d", k), {31'h0, mem_rd_o}, 32'h1);
      chk($sformatf("busy%0d", k), {31'h0, busy_o}, 32'h1);
      a = exp_addr(line, hires, page2, bank, k);
      chk($sformatf("addr%0d", k), {11'h0, mem_addr_o}, a);
      if (k == 0 && exp_first >= 0) chk("first_addr", {11'h0, mem_addr_o}, 32'(exp_first));
      if (k == reset_at) begin
        system_reset = 1'b1;
        tick();
        chk("rst_rd", {31'h0, mem_rd_o}, 32'h0);
        chk("rst_busy", {31'h0, busy_o}, 32'h0);
        chk("rst_done", {31'h0, line_done_o}, 32'h0);
        system_reset = 1'b0;
        tick();
        return;
      end
      if (k == overrun_at) begin
        line_start_i = 1'b1;
        tick();
        line_start_i = 1'b0;
        chk("overrun_pulse", {31'h0, overrun_o}, 32'h1);
        chk("overrun_addr", {11'h0, mem_addr_o}, a);
      end
      stall = (k == long_stall_at) ? 7 : $urandom_range(0, 2);
      for (int s = 0; s < stall; s++) begin
        if (k != long_stall_at) mem_available_i = 1'($urandom);  // ignored in REQ without ready
        mem_q_i = $urandom;
        tick();
        mem_available_i = 1'b0;
        chk($sformatf("stall_rd%0d", k), {31'h0, mem_rd_o}, 32'h1);
        chk($sformatf("stall_addr%0d", k), {11'h0, mem_addr_o}, a);
      end
      mem_ready_i = 1'b1;
      if (mix && $urandom_range(0, 1) == 1) begin
        mem_available_i = 1'b1;
        mem_q_i = wdata[k];
        tick();
        mem_ready_i = 1'b0;
        mem_available_i = 1'b0;
      end else begin
        tick();
        mem_ready_i = 1'b0;
        chk($sformatf("wait_rd%0d", k), {31'h0, mem_rd_o}, 32'h0);
        for (int d = $urandom_range(0, 3); d > 0; d--) tick();
        mem_available_i = 1'b1;
        mem_q_i = wdata[k];
        tick();
        mem_available_i = 1'b0;
      end
      mem_q_i = $urandom;
    end
    chk("line_done", {31'h0, line_done_o}, 32'h1);
    for (int k = 0; k < 20; k++) begin
      model[2*k]   = wdata[k][15:0];
      model[2*k+1] = wdata[k][31:16];
    end
    if (start_at_done) begin
      line_start_i = 1'b1;
      tick();
      line_start_i = 1'b0;
      chk("done_overrun", {31'h0, overrun_o}, 32'h1);
      chk("done_no_refetch", {31'h0, mem_rd_o}, 32'h0);
    end else begin
      tick();
    end
    chk("idle_busy", {31'h0, busy_o}, 32'h0);
    chk("done_pulse_end", {31'h0, line_done_o}, 32'h0);
  endtask

  initial begin
    int n;
    bit got_to;
    bit got_done;

    system_reset = 1'b1;
    tick(); tick(); tick();
    system_reset = 1'b0;
    chk("reset_rd", {31'h0, mem_rd_o}, 32'h0);
    chk("reset_busy", {31'h0, busy_o}, 32'h0);
    chk("reset_done", {31'h0, line_done_o}, 32'h0);
    chk("reset_overrun", {31'h0, overrun_o}, 32'h0);
    chk("reset_timeout", {31'h0, timeout_o}, 32'h0);
    chk("reset_addr", {11'h0, mem_addr_o}, 32'h0);
    chk("reset_buf", {16'h0, buf_data_o}, 32'h0);

    run_line(0, 0, 0, 0, 'h000200, -1, -1, -1, 0, 0, 1);
    check_buffer("t1");
    buf_addr_i = 6'd10; tick();
    chk("word5_lo", {16'h0, buf_data_o}, 32'h0000BBAA);
    buf_addr_i = 6'd11; tick();
    chk("word5_hi", {16'h0, buf_data_o}, 32'h0000DDCC);

    run_line(184, 0, 0, 0, 'h0003E8, 2, -1, -1, 0, 0, 0);
    check_buffer("t2");
    run_line(191, 1, 1, 1, 'h00AFE8, -1, -1, -1, 1, 1, 0);
    check_buffer("t3");
    run_line(1, 1, 0, 0, 'h001200, -1, 3, -1, 1, 0, 0);
    check_buffer("t4");

    // Data never returns: line must abort after the timeout window, no swap.
    line_i = 8'd50; hires_i = 1'b0; page2_i = 1'b0; bank_i = 1'b0;
    line_start_i = 1'b1; tick(); line_start_i = 1'b0;
    n = 0;
    while (!mem_rd_o && n < 20) begin tick(); n++; end
    mem_ready_i = 1'b1; tick(); mem_ready_i = 1'b0;
    n = 0; got_to = 0; got_done = 0;
    while (n < 300 && !got_to) begin
      tick(); n++;
      if (line_done_o) got_done = 1;
      if (timeout_o) got_to = 1;
    end
    chk("timeout_seen", {31'h0, got_to}, 32'h1);
    chk("timeout_cycles", 32'(n), 32'd255);
    chk("timeout_no_done", {31'h0, got_done}, 32'h0);
    chk("timeout_busy", {31'h0, busy_o}, 32'h0);
    tick();
    chk("timeout_pulse_end", {31'h0, timeout_o}, 32'h0);
    check_buffer("t5");

    run_line(77, 0, 1, 1, -1, -1, -1, 10, 0, 0, 0);

    for (int i = 0; i < 3; i++) begin
      run_line($urandom_range(0, 191), 1'($urandom), 1'($urandom), 1'($urandom),
               -1, -1, -1, -1, 1, 0, 0);
      check_buffer($sformatf("r%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
